// File: rtl/wrr_grant_datapath.sv
// rtl/wrr_grant_datapath.sv - routes the granted client's beats into a 2-entry skid FIFO with source tags
// Optional macro GNT_ONEHOT_CHECK_EN: multi-hot grants block acceptance and set sticky o_err.
module wrr_grant_datapath #(
    parameter int NUM_CLIENTS = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_CLIENTS-1:0]            i_gnt,
    input  logic [NUM_CLIENTS-1:0]            i_valid,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] i_data,
    input  logic [NUM_CLIENTS-1:0]            i_lock,
    output logic [NUM_CLIENTS-1:0]            o_ready,
    output logic                              o_valid,
    output logic [DATA_WIDTH-1:0]             o_data,
    output logic [$clog2(NUM_CLIENTS)-1:0]    o_src,
    output logic                              o_lock,
    input  logic                              i_ready,
    output logic [CNT_WIDTH-1:0]              o_beat_cnt,
    output logic                              o_err
);
    localparam int SRC_W = $clog2(NUM_CLIENTS);
    localparam logic [NUM_CLIENTS-1:0] GNT_ONE = NUM_CLIENTS'(1);

    logic [1:0]             count;
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [DATA_WIDTH-1:0]  mem_data [2];
    logic [SRC_W-1:0]       mem_src  [2];
    logic                   mem_lock [2];

    logic [NUM_CLIENTS-1:0] sel;
    logic [SRC_W-1:0]       sel_idx;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   sel_lock;
    logic                   sel_valid;
    logic                   can_push;
    logic                   push;
    logic                   pop;

`ifdef GNT_ONEHOT_CHECK_EN
    logic multi_hot;
    logic err_q;

    assign multi_hot = |(i_gnt & (i_gnt - GNT_ONE));
    assign sel       = multi_hot ? '0 : i_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (multi_hot) begin
            err_q <= 1'b1;
        end
    end
    assign o_err = err_q;
`else
    // Isolate the lowest set bit so a multi-hot grant still selects exactly one client.
    assign sel   = i_gnt & (~i_gnt + GNT_ONE);
    assign o_err = 1'b0;
`endif

    always_comb begin
        sel_idx  = '0;
        sel_data = '0;
        sel_lock = 1'b0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            if (sel[k]) begin
                sel_idx  = SRC_W'(k);
                sel_data = i_data[k*DATA_WIDTH +: DATA_WIDTH];
                sel_lock = i_lock[k];
            end
        end
    end

    // Ready is a function of registered count only, so no i_ready -> o_ready path exists.
    assign can_push  = (count < 2'd2);
    assign o_ready   = sel & {NUM_CLIENTS{can_push}};
    assign sel_valid = |(sel & i_valid);
    assign push      = sel_valid & can_push;
    assign pop       = (count != 2'd0) & i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            o_beat_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
                if (o_beat_cnt != {CNT_WIDTH{1'b1}}) begin
                    o_beat_cnt <= o_beat_cnt + 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= sel_data;
            mem_src[wr_ptr]  <= sel_idx;
            mem_lock[wr_ptr] <= sel_lock;
        end
    end

    assign o_valid = (count != 2'd0);
    assign o_data  = o_valid ? mem_data[rd_ptr] : '0;
    assign o_src   = o_valid ? mem_src[rd_ptr]  : '0;
    assign o_lock  = o_valid ? mem_lock[rd_ptr] : 1'b0;
endmodule

// File: tb/tb_wrr_grant_datapath.sv
// tb/tb_wrr_grant_datapath.sv - table-driven directed bench for wrr_grant_datapath
module tb_wrr_grant_datapath;
    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   i_gnt;
    logic [3:0]   i_valid;
    logic [127:0] i_data;
    logic [3:0]   i_lock;
    logic [3:0]   o_ready;
    logic         o_valid;
    logic [31:0]  o_data;
    logic [1:0]   o_src;
    logic         o_lock;
    logic         i_ready;
    logic [2:0]   o_beat_cnt;
    logic         o_err;

    int n_applied = 0;
    int n_miss    = 0;

    wrr_grant_datapath #(.NUM_CLIENTS(4), .DATA_WIDTH(32), .CNT_WIDTH(3)) dut (
        .clk(clk), .rst(rst), .i_gnt(i_gnt), .i_valid(i_valid), .i_data(i_data),
        .i_lock(i_lock), .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data),
        .o_src(o_src), .o_lock(o_lock), .i_ready(i_ready), .o_beat_cnt(o_beat_cnt),
        .o_err(o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  gnt;
        logic [3:0]  valid;
        logic [31:0] d;
        logic [3:0]  lock;
        logic        rdy;
        logic [3:0]  e_ready;
        logic        e_valid;
        logic [31:0] e_data;
        logic [1:0]  e_src;
        logic        e_lock;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(logic [3:0] gnt, logic [3:0] valid, logic [31:0] d,
                                logic [3:0] lock, logic rdy, logic [3:0] e_ready,
                                logic e_valid, logic [31:0] e_data, logic [1:0] e_src,
                                logic e_lock, logic [2:0] e_cnt);
        vec_t v;
        v.gnt = gnt; v.valid = valid; v.d = d; v.lock = lock; v.rdy = rdy;
        v.e_ready = e_ready; v.e_valid = e_valid; v.e_data = e_data;
        v.e_src = e_src; v.e_lock = e_lock; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_gnt = '0; i_valid = '0; i_data = '0; i_lock = '0; i_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();

        // Test 1: reset with random inputs
        repeat (3) begin
            i_gnt = 4'($urandom); i_valid = 4'($urandom); i_lock = 4'($urandom);
            i_data = {$urandom, $urandom, $urandom, $urandom}; i_ready = 1'($urandom);
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_cnt",   32'(o_beat_cnt), 32'd0);
        chk("rst_err",   32'(o_err), 32'd0);
        chk("rst_data",  o_data, 32'd0);
        tick();

        // Tests 2-4: single stream, backpressure, grant switch
        tbl[0]  = mk(4'b0010, 4'b0010, 32'h10, 4'b0000, 1'b1, 4'b0010, 1'b0, 32'h00, 2'd0, 1'b0, 3'd0);
        tbl[1]  = mk(4'b0010, 4'b0010, 32'h11, 4'b0000, 1'b1, 4'b0010, 1'b1, 32'h10, 2'd1, 1'b0, 3'd1);
        tbl[2]  = mk(4'b0010, 4'b0010, 32'h12, 4'b0000, 1'b1, 4'b0010, 1'b1, 32'h11, 2'd1, 1'b0, 3'd2);
        tbl[3]  = mk(4'b0000, 4'b0000, 32'h00, 4'b0000, 1'b1, 4'b0000, 1'b1, 32'h12, 2'd1, 1'b0, 3'd3);
        tbl[4]  = mk(4'b0000, 4'b0000, 32'h00, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h00, 2'd0, 1'b0, 3'd3);
        tbl[5]  = mk(4'b0001, 4'b0001, 32'hA0, 4'b0000, 1'b0, 4'b0001, 1'b0, 32'h00, 2'd0, 1'b0, 3'd3);
        tbl[6]  = mk(4'b0001, 4'b0001, 32'hA1, 4'b0000, 1'b0, 4'b0001, 1'b1, 32'hA0, 2'd0, 1'b0, 3'd4);
        tbl[7]  = mk(4'b0001, 4'b0001, 32'hA2, 4'b0000, 1'b0, 4'b0000, 1'b1, 32'hA0, 2'd0, 1'b0, 3'd5);
        tbl[8]  = mk(4'b0001, 4'b0001, 32'hA2, 4'b0000, 1'b1, 4'b0000, 1'b1, 32'hA0, 2'd0, 1'b0, 3'd5);
        tbl[9]  = mk(4'b0001, 4'b0001, 32'hA2, 4'b0000, 1'b1, 4'b0001, 1'b1, 32'hA1, 2'd0, 1'b0, 3'd5);
        tbl[10] = mk(4'b0000, 4'b0000, 32'h00, 4'b0000, 1'b1, 4'b0000, 1'b1, 32'hA2, 2'd0, 1'b0, 3'd6);
        tbl[11] = mk(4'b0000, 4'b0000, 32'h00, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h00, 2'd0, 1'b0, 3'd6);
        tbl[12] = mk(4'b0100, 4'b0100, 32'h20, 4'b0100, 1'b1, 4'b0100, 1'b0, 32'h00, 2'd0, 1'b0, 3'd6);
        tbl[13] = mk(4'b0100, 4'b0100, 32'h21, 4'b0100, 1'b1, 4'b0100, 1'b1, 32'h20, 2'd2, 1'b1, 3'd7);
        tbl[14] = mk(4'b1000, 4'b1000, 32'h30, 4'b0000, 1'b1, 4'b1000, 1'b1, 32'h21, 2'd2, 1'b1, 3'd7);
        tbl[15] = mk(4'b1000, 4'b1000, 32'h31, 4'b0000, 1'b1, 4'b1000, 1'b1, 32'h30, 2'd3, 1'b0, 3'd7);
        tbl[16] = mk(4'b0000, 4'b0000, 32'h00, 4'b0000, 1'b1, 4'b0000, 1'b1, 32'h31, 2'd3, 1'b0, 3'd7);
        tbl[17] = mk(4'b0000, 4'b0000, 32'h00, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h00, 2'd0, 1'b0, 3'd7);

        for (int i = 0; i < 18; i++) begin
            i_gnt = tbl[i].gnt; i_valid = tbl[i].valid; i_data = {4{tbl[i].d}};
            i_lock = tbl[i].lock; i_ready = tbl[i].rdy;
            #1;
            chk($sformatf("v%0d_ready", i), 32'(o_ready), 32'(tbl[i].e_ready));
            chk($sformatf("v%0d_valid", i), 32'(o_valid), 32'(tbl[i].e_valid));
            chk($sformatf("v%0d_data", i),  o_data,       tbl[i].e_data);
            chk($sformatf("v%0d_src", i),   32'(o_src),   32'(tbl[i].e_src));
            chk($sformatf("v%0d_lock", i),  32'(o_lock),  32'(tbl[i].e_lock));
            chk($sformatf("v%0d_cnt", i),   32'(o_beat_cnt), 32'(tbl[i].e_cnt));
            tick();
        end

        // Grant all zero while clients are valid: nothing accepted
        i_gnt = 4'b0000; i_valid = 4'b1111; i_ready = 1'b1;
        #1;
        chk("nognt_ready", 32'(o_ready), 32'd0);
        tick();
        chk("nognt_valid", 32'(o_valid), 32'd0);

        // Reset mid-operation discards buffered beats
        i_gnt = 4'b0001; i_valid = 4'b0001; i_ready = 1'b0; i_data = {4{32'h55}};
        repeat (2) tick();
        chk("mid_full", 32'(o_valid), 32'd1);
        do_reset();
        #1;
        chk("mid_rst_valid", 32'(o_valid), 32'd0);
        chk("mid_rst_cnt",   32'(o_beat_cnt), 32'd0);
        tick();

        // Test 5: counter saturation at 7 over 10 pushes
        i_gnt = 4'b0100; i_valid = 4'b0100; i_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            i_data = {4{32'(i)}};
            tick();
            chk($sformatf("sat_cnt%0d", i), 32'(o_beat_cnt), (i + 1 > 7) ? 32'd7 : 32'(i + 1));
        end
        idle_inputs();
        do_reset();
        tick();

        // Test 6: multi-hot grant
        i_gnt = 4'b0110; i_valid = 4'b0110; i_ready = 1'b1; i_lock = 4'b0010;
        i_data = {32'h63, 32'h62, 32'h61, 32'h60};
        #1;
`ifdef GNT_ONEHOT_CHECK_EN
        chk("mh_ready", 32'(o_ready), 32'd0);
        chk("mh_err_pre", 32'(o_err), 32'd0);
        tick();
        i_gnt = 4'b0010; i_valid = 4'b0000;
        #1;
        chk("mh_err", 32'(o_err), 32'd1);
        chk("mh_nopush", 32'(o_valid), 32'd0);
        chk("mh_cnt", 32'(o_beat_cnt), 32'd0);
        tick();
        chk("mh_err_sticky", 32'(o_err), 32'd1);
`else
        chk("mh_ready", 32'(o_ready), 32'b0010);
        tick();
        i_gnt = 4'b0000; i_valid = 4'b0000; i_ready = 1'b0;
        #1;
        chk("mh_valid", 32'(o_valid), 32'd1);
        chk("mh_data",  o_data, 32'h61);
        chk("mh_src",   32'(o_src), 32'd1);
        chk("mh_lock",  32'(o_lock), 32'd1);
        chk("mh_cnt",   32'(o_beat_cnt), 32'd1);
        chk("mh_err",   32'(o_err), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end
endmodule
